garage_system: RTL and testbench
================================

Name: garage_system

Overview:
Parking-garage occupancy controller. Counts cars present, grants entry and exit requests with one-cycle door-open pulses, and flags when the garage is full. Sits between the entry/exit request sensors and the door actuators/status display. Single clock domain, fully synchronous.

Parameters:
MAX_NUM, 10, garage capacity (maximum cars held); legal range 1..2^LOG_MAX_NUM-1
LOG_MAX_NUM, 4, width of the occupancy counter; must satisfy 2^LOG_MAX_NUM > MAX_NUM

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  synchronous, active-high reset; asserted when 1 despite the suffix
car_entry_request  input  1  level request from entry sensor
car_exit_request  input  1  level request from exit sensor
open_entry_door  output  1  registered one-cycle pulse: entry granted
open_exit_door  output  1  registered one-cycle pulse: exit granted
garage_is_complete  output  1  high while occupancy == MAX_NUM

Behaviour:
- Internal occupancy register named counter, LOG_MAX_NUM bits, unsigned. Benches probe it hierarchically by this name.
- Reset (reset_n=1 at a rising edge):
  - counter=0, open_entry_door=0, open_exit_door=0, garage_is_complete=0.
  - Request edge-detect registers cleared to 0.
  - Reset has priority over all requests, including mid-operation; any request in that cycle is discarded.
- Request qualification: rising-edge detect per input. entry_evt = car_entry_request & ~entry_q, with entry_q registered each cycle; exit_evt is formed the same way.
  - A request held high for N cycles counts once.
  - A request high in the first cycle after reset release counts as an event.
- Grant rules, evaluated on the counter value before the edge:
  - entry_ok = entry_evt & (counter != MAX_NUM)
  - exit_ok = exit_evt & (counter != 0)
- Counter update at the same edge:
  - entry_ok only: +1
  - exit_ok only: -1
  - both: unchanged
  - neither: unchanged
- Counter never wraps: no increment at MAX_NUM, no decrement at 0.
- Simultaneous entry and exit events:
  - 0 < counter < MAX_NUM: both doors pulse, counter unchanged.
  - counter == MAX_NUM: exit granted only, counter becomes MAX_NUM-1, no entry pulse.
  - counter == 0: entry granted only, counter becomes 1, no exit pulse.
- Doors:
  - open_entry_door <= entry_ok; open_exit_door <= exit_ok.
  - Each is high for exactly one cycle after the granting edge, with 1-cycle latency from the qualifying request sample.
  - Denied requests produce no pulse and are not queued.
- garage_is_complete: registered, equals (counter_next == MAX_NUM). It tracks the counter with no extra cycle of lag, i.e. it asserts in the same cycle counter reaches MAX_NUM.

Optional Feature:
Macro GARAGE_STATUS_EN.
- Defined: adds two outputs.
  - car_count, LOG_MAX_NUM bits, mirrors counter.
  - garage_is_empty, 1 bit, registered, high while counter == 0; resets to 1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset held 1 cycle, then released -> counter=0, open_entry_door=0, open_exit_door=0, garage_is_complete=0.
2. Eleven single-cycle entry pulses separated by idle cycles from empty:
   - First ten each give a one-cycle open_entry_door and counter 1..10.
   - garage_is_complete=1 when counter=10.
   - Eleventh pulse gives no door pulse; counter stays 10.
3. From full, eleven single-cycle exit pulses:
   - First ten each give a one-cycle open_exit_door and counter 9..0.
   - garage_is_complete drops at the first exit.
   - Eleventh pulse at counter=0 gives no pulse; counter stays 0.
4. Entry request held high 5 cycles at counter=3 -> exactly one open_entry_door pulse; counter=4.
5. Simultaneous entry and exit edges at three counts:
   - counter=5: both doors pulse, counter=5.
   - counter=10: only exit door, counter=9.
   - counter=0: only entry door, counter=1.
6. counter=7, reset asserted in the same cycle as an entry edge -> counter=0, no door pulse, garage_is_complete=0.
   - With GARAGE_STATUS_EN defined: garage_is_empty=1 and car_count=0.

Source files
------------

// File: rtl/garage_system.sv
// Parking-garage occupancy controller: counts cars, grants entry/exit with
// one-cycle door pulses, flags full. Optional status outputs (car_count,
// garage_is_empty) are enabled by defining GARAGE_STATUS_EN.
module garage_system #(
    parameter int unsigned MAX_NUM     = 10,
    parameter int unsigned LOG_MAX_NUM = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,            // active-high despite the name
    input  logic                   car_entry_request,
    input  logic                   car_exit_request,
    output logic                   open_entry_door,
    output logic                   open_exit_door,
    output logic                   garage_is_complete
`ifdef GARAGE_STATUS_EN
    ,
    output logic [LOG_MAX_NUM-1:0] car_count,
    output logic                   garage_is_empty
`endif
);

    localparam logic [LOG_MAX_NUM-1:0] FULL_CNT = LOG_MAX_NUM'(MAX_NUM);
    localparam logic [LOG_MAX_NUM-1:0] ONE_CNT  = LOG_MAX_NUM'(1);

    // Occupancy register keeps its plain name so it can be probed directly.
    logic [LOG_MAX_NUM-1:0] counter;
    logic [LOG_MAX_NUM-1:0] counter_d;

    logic entry_q, entry_d;
    logic exit_q, exit_d;
    logic open_entry_door_q, open_entry_door_d;
    logic open_exit_door_q, open_exit_door_d;
    logic garage_is_complete_q, garage_is_complete_d;

    logic entry_evt_c;
    logic exit_evt_c;
    logic entry_ok_c;
    logic exit_ok_c;

    // Rising-edge qualification and grant decision against the current count.
    always_comb begin
        entry_evt_c = car_entry_request & ~entry_q;
        exit_evt_c  = car_exit_request & ~exit_q;
        entry_ok_c  = entry_evt_c & (counter != FULL_CNT);
        exit_ok_c   = exit_evt_c & (counter != '0);
    end

    // Next-state: counter update, door pulses and full flag from the new count.
    always_comb begin
        counter_d            = counter;
        entry_d              = car_entry_request;
        exit_d               = car_exit_request;
        open_entry_door_d    = entry_ok_c;
        open_exit_door_d     = exit_ok_c;

        unique case ({entry_ok_c, exit_ok_c})
            2'b10:   counter_d = counter + ONE_CNT;
            2'b01:   counter_d = counter - ONE_CNT;
            default: counter_d = counter;
        endcase

        garage_is_complete_d = (counter_d == FULL_CNT);
    end

    // State registers; reset wins over any request in the same cycle.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            counter              <= '0;
            entry_q              <= 1'b0;
            exit_q               <= 1'b0;
            open_entry_door_q    <= 1'b0;
            open_exit_door_q     <= 1'b0;
            garage_is_complete_q <= 1'b0;
        end else begin
            counter              <= counter_d;
            entry_q              <= entry_d;
            exit_q               <= exit_d;
            open_entry_door_q    <= open_entry_door_d;
            open_exit_door_q     <= open_exit_door_d;
            garage_is_complete_q <= garage_is_complete_d;
        end
    end

    assign open_entry_door    = open_entry_door_q;
    assign open_exit_door     = open_exit_door_q;
    assign garage_is_complete = garage_is_complete_q;

`ifdef GARAGE_STATUS_EN
    logic garage_is_empty_q, garage_is_empty_d;

    // Empty flag tracks the next count so it changes with the counter.
    always_comb begin
        garage_is_empty_d = (counter_d == '0);
    end

    // Empty flag register; an empty garage is the reset condition.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            garage_is_empty_q <= 1'b1;
        end else begin
            garage_is_empty_q <= garage_is_empty_d;
        end
    end

    assign car_count       = counter;
    assign garage_is_empty = garage_is_empty_q;
`endif

endmodule

// File: tb/tb_garage_system.sv
// Directed self-checking bench for garage_system (MAX_NUM=10).
module tb_garage_system;

    localparam int unsigned MAXN = 10;
    localparam int unsigned LW   = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic car_entry_request;
    logic car_exit_request;
    logic open_entry_door;
    logic open_exit_door;
    logic garage_is_complete;
`ifdef GARAGE_STATUS_EN
    logic [LW-1:0] car_count;
    logic          garage_is_empty;
`endif

    int checks   = 0;
    int failures = 0;

    garage_system #(.MAX_NUM(MAXN), .LOG_MAX_NUM(LW)) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .car_entry_request  (car_entry_request),
        .car_exit_request   (car_exit_request),
        .open_entry_door    (open_entry_door),
        .open_exit_door     (open_exit_door),
        .garage_is_complete (garage_is_complete)
`ifdef GARAGE_STATUS_EN
        ,
        .car_count          (car_count),
        .garage_is_empty    (garage_is_empty)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs change only here.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Check all visible state after an edge.
    task automatic chk_all(input string tag, input int cnt, input bit ed, input bit xd);
        chk({tag, ".counter"}, 32'(dut.counter), 32'(cnt));
        chk({tag, ".entry_door"}, 32'(open_entry_door), 32'(ed));
        chk({tag, ".exit_door"}, 32'(open_exit_door), 32'(xd));
        chk({tag, ".complete"}, 32'(garage_is_complete), 32'(cnt == MAXN));
`ifdef GARAGE_STATUS_EN
        chk({tag, ".car_count"}, 32'(car_count), 32'(cnt));
        chk({tag, ".empty"}, 32'(garage_is_empty), 32'(cnt == 0));
`endif
    endtask

    // One-cycle request pulse followed by an idle cycle, fully checked.
    task automatic pulse(input string tag, input bit e, input bit x,
                         input int cnt_after, input bit ed, input bit xd);
        car_entry_request = e;
        car_exit_request  = x;
        cyc();
        chk_all(tag, cnt_after, ed, xd);
        car_entry_request = 1'b0;
        car_exit_request  = 1'b0;
        cyc();
        chk_all({tag, ".idle"}, cnt_after, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        reset_n           = 1'b1;
        car_entry_request = 1'b0;
        car_exit_request  = 1'b0;
        #1;

        // 1: reset
        cyc();
        chk_all("reset", 0, 1'b0, 1'b0);
        reset_n = 1'b0;
        cyc();
        chk_all("post_reset", 0, 1'b0, 1'b0);

        // 2: fill to capacity, eleventh entry denied
        cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i <= 10) begin
                cnt = i;
                pulse($sformatf("fill%0d", i), 1'b1, 1'b0, cnt, 1'b1, 1'b0);
            end else begin
                pulse("fill_denied", 1'b1, 1'b0, 10, 1'b0, 1'b0);
            end
        end

        // 3: drain to empty, eleventh exit denied
        for (int i = 1; i <= 11; i++) begin
            if (i <= 10) begin
                cnt = 10 - i;
                pulse($sformatf("drain%0d", i), 1'b0, 1'b1, cnt, 1'b0, 1'b1);
            end else begin
                pulse("drain_denied", 1'b0, 1'b1, 0, 1'b0, 1'b0);
            end
        end

        // 4: held entry at counter=3 counts once
        for (int i = 1; i <= 3; i++) pulse("to3", 1'b1, 1'b0, i, 1'b1, 1'b0);
        car_entry_request = 1'b1;
        cyc();
        chk_all("hold_c1", 4, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            cyc();
            chk_all($sformatf("hold_c%0d", i), 4, 1'b0, 1'b0);
        end
        car_entry_request = 1'b0;
        cyc();
        chk_all("hold_rel", 4, 1'b0, 1'b0);

        // 5: simultaneous edges at 5, 10, 0
        pulse("to5", 1'b1, 1'b0, 5, 1'b1, 1'b0);
        pulse("both_at5", 1'b1, 1'b1, 5, 1'b1, 1'b1);
        for (int i = 6; i <= 10; i++) pulse("to10", 1'b1, 1'b0, i, 1'b1, 1'b0);
        pulse("both_at10", 1'b1, 1'b1, 9, 1'b0, 1'b1);
        for (int i = 8; i >= 0; i--) pulse("to0", 1'b0, 1'b1, i, 1'b0, 1'b1);
        pulse("both_at0", 1'b1, 1'b1, 1, 1'b1, 1'b0);

        // 6: reset collides with an entry edge at counter=7
        for (int i = 2; i <= 7; i++) pulse("to7", 1'b1, 1'b0, i, 1'b1, 1'b0);
        reset_n           = 1'b1;
        car_entry_request = 1'b1;
        cyc();
        chk_all("reset_vs_entry", 0, 1'b0, 1'b0);
        // Request still high on the first cycle after release counts as an edge.
        reset_n = 1'b0;
        cyc();
        chk_all("entry_after_reset", 1, 1'b1, 1'b0);
        car_entry_request = 1'b0;
        cyc();
        chk_all("final_idle", 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
